// File: rtl/sad_min_search_pkg.sv
// Shared definitions for the SAD engine, C memory model and minimum search.
// This package holds the default sizes and the scan state encoding.
package sad_min_search_pkg;

    localparam int DEF_N_ENTRIES = 128;
    localparam int DEF_ADDR_W    = 7;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_LAT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/sad_rd_tag_pipe.sv
// Read tag pipeline: a LAT-stage shift of {valid, index} that follows each
// issued C memory read so the returning word arrives paired with its address.
module sad_rd_tag_pipe #(
    parameter int LAT   = 2,
    parameter int IDX_W = 7
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             any_valid
);

    logic [LAT-1:0]   valid_q;
    logic [IDX_W-1:0] idx_q [LAT];

    // Valid bits shift every cycle; reset drops any reads still in flight.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments here make every stage sample the
        // previous stage's old value, which is what a shift register needs.
        if (!Rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int s = 1; s < LAT; s++) begin
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    // Index bits shift alongside the valid bits.
    always_ff @(posedge Clk) begin
        // NOTE: the index stages carry no reset; they are meaningless unless the
        // matching valid bit is set, and the valid bits are reset above.
        idx_q[0] <= in_idx;
        for (int s = 1; s < LAT; s++) begin
            idx_q[s] <= idx_q[s-1];
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_idx   = idx_q[LAT-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/sad_min_search.sv
// Minimum-SAD search: scans C memory one read per cycle, tracks the smallest
// SAD word and its address, and reports it with a threshold flag and Done pulse.
module sad_min_search
    import sad_min_search_pkg::*;
#(
    parameter int N_ENTRIES = DEF_N_ENTRIES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_LAT   = DEF_MEM_LAT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Go,
    input  logic [DATA_W-1:0] Thresh,
    input  logic [DATA_W-1:0] C_in,
    output logic [ADDR_W-1:0] C_Addr,
    output logic              C_En,
    output logic              C_Rw,
    output logic [DATA_W-1:0] Min_Sad,
    output logic [ADDR_W-1:0] Min_Idx,
    output logic              Below_Thr,
    output logic              Busy,
    output logic              Done
);

    // One extra bit lets N_ENTRIES == 2**ADDR_W finish without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ENTRIES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    scan_state_e       state_q, state_nx;
    logic [CNT_W-1:0]  issue_cnt;
    logic [DATA_W-1:0] thresh_q;
    logic [DATA_W-1:0] best_q;
    logic [ADDR_W-1:0] best_idx_q;

    logic              go_start;
    logic              fin_entry;
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_idx;
    logic              tag_any;

    assign go_start  = (state_q == ST_IDLE) && Go;
    assign fin_entry = (state_q == ST_DRAIN) && !tag_any;

    // C memory is only ever read by this block.
    assign C_Rw = 1'b0;

    sad_rd_tag_pipe #(
        .LAT   (MEM_LAT),
        .IDX_W (ADDR_W)
    ) u_tag_pipe (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (state_q == ST_READ),
        .in_idx    (issue_cnt[ADDR_W-1:0]),
        .out_valid (tag_valid),
        .out_idx   (tag_idx),
        .any_valid (tag_any)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nx;
    end

    // Next-state logic: read all entries, drain the tag pipe, publish, return.
    always_comb begin
        // NOTE: assigning the default first keeps every path covered, so no latch.
        state_nx = state_q;
        unique case (state_q)
            ST_IDLE:  if (Go) state_nx = ST_READ;
            ST_READ:  if (issue_cnt == CNT_LAST) state_nx = ST_DRAIN;
            ST_DRAIN: if (!tag_any) state_nx = ST_FIN;
            ST_FIN:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Issue counter and threshold capture at scan start.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            issue_cnt <= '0;
            thresh_q  <= '0;
        end else if (go_start) begin
            issue_cnt <= '0;
            thresh_q  <= Thresh;
        end else if (state_q == ST_READ) begin
            issue_cnt <= issue_cnt + CNT_ONE;
        end
    end

    // Registered C memory address/enable: one read per READ cycle, idle otherwise.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            C_Addr <= '0;
            C_En   <= 1'b0;
        end else if (state_q == ST_READ) begin
            C_Addr <= issue_cnt[ADDR_W-1:0];
            C_En   <= 1'b1;
        end else begin
            C_Addr <= '0;
            C_En   <= 1'b0;
        end
    end

    // Running minimum; strict compare keeps the lowest index on ties.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            best_q     <= '0;
            best_idx_q <= '0;
        end else if (go_start) begin
            best_q     <= '1;
            best_idx_q <= '0;
        end else if (tag_valid && (C_in < best_q)) begin
            best_q     <= C_in;
            best_idx_q <= tag_idx;
        end
    end

    // Result registers update only when the scan completes; Done is a pulse.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Min_Sad   <= '0;
            Min_Idx   <= '0;
            Below_Thr <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= fin_entry;
            if (fin_entry) begin
                Min_Sad   <= best_q;
                Min_Idx   <= best_idx_q;
                Below_Thr <= (best_q < thresh_q);
            end
        end
    end

    // Busy covers the READ and DRAIN states.
    always_ff @(posedge Clk) begin
        if (!Rst_n) Busy <= 1'b0;
        else        Busy <= (state_nx == ST_READ) || (state_nx == ST_DRAIN);
    end

endmodule

// File: tb/tb_sad_min_search.sv
// Self-checking bench for sad_min_search: C memory model with two-edge read
// timing, scoreboard of expected scan results, directed scenarios.
module tb_sad_min_search;
    import sad_min_search_pkg::*;

    localparam int N       = DEF_N_ENTRIES;
    localparam int AW      = DEF_ADDR_W;
    localparam int DW      = DEF_DATA_W;
    localparam int ML      = DEF_MEM_LAT;
    localparam int LATENCY = N + ML + 1;   // Go edge to Done edge
    localparam int PERIOD  = N + ML + 3;   // Go-held restart interval

    typedef struct {
        logic [DW-1:0] sad;
        logic [AW-1:0] idx;
        logic          below;
        int            go_edge;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          Go;
    logic [DW-1:0] Thresh;
    logic [DW-1:0] C_in;
    logic [AW-1:0] C_Addr;
    logic          C_En;
    logic          C_Rw;
    logic [DW-1:0] Min_Sad;
    logic [AW-1:0] Min_Idx;
    logic          Below_Thr;
    logic          Busy;
    logic          Done;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t last_exp;
    logic prev_done = 1'b0;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] rd_q;

    sad_min_search dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Go        (Go),
        .Thresh    (Thresh),
        .C_in      (C_in),
        .C_Addr    (C_Addr),
        .C_En      (C_En),
        .C_Rw      (C_Rw),
        .Min_Sad   (Min_Sad),
        .Min_Idx   (Min_Idx),
        .Below_Thr (Below_Thr),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // C memory: address registered by the DUT, data registered here.
    always @(posedge Clk) rd_q <= C_En ? mem[C_Addr] : 32'hDEAD_BEEF;
    assign C_in = rd_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: C_Rw every cycle, Done width, and scoreboard compare on Done.
    always @(negedge Clk) begin
        exp_t e;
        chk("c_rw_read", C_Rw, 0);
        if (prev_done) chk("done_width", Done, 0);
        if (Done === 1'b1 && !prev_done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", Done, 0);
            end else begin
                e = exp_q.pop_front();
                chk("min_sad", Min_Sad, e.sad);
                chk("min_idx", Min_Idx, e.idx);
                chk("below_thr", Below_Thr, e.below);
                chk("done_latency", cyc - e.go_edge, LATENCY);
                chk("busy_at_done", Busy, 0);
            end
        end
        prev_done <= (Done === 1'b1);
    end

    function automatic exp_t model(input logic [DW-1:0] thr);
        exp_t e;
        e.sad = '1;
        e.idx = '0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] < e.sad) begin
                e.sad = mem[i];
                e.idx = AW'(i);
            end
        end
        e.below   = (e.sad < thr);
        e.go_edge = 0;
        return e;
    endfunction

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge Clk);
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge Clk);
            n++;
        end
        chk("done_timeout", exp_q.size(), 0);
    endtask

    // Pulse Go for one edge (called at a negedge); returns the Go edge number.
    task automatic start_scan(input logic [DW-1:0] thr, input exp_t e, output int g);
        Go     = 1'b1;
        Thresh = thr;
        g      = cyc + 1;
        e.go_edge = g;
        exp_q.push_back(e);
        last_exp = e;
        @(negedge Clk);
        Go = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_min_sad"}, Min_Sad, 0);
        chk({tag, "_min_idx"}, Min_Idx, 0);
        chk({tag, "_below"}, Below_Thr, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_c_en"}, C_En, 0);
        chk({tag, "_c_addr"}, C_Addr, 0);
    endtask

    initial begin
        exp_t e;
        int   g;

        Rst_n  = 1'b0;
        Go     = 1'b0;
        Thresh = '0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) @(negedge Clk);
        chk_zero("reset");
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        // 1: descending ramp, minimum at the last address.
        for (int i = 0; i < N; i++) mem[i] = 32'(1000 - i);
        e.sad = 32'd873; e.idx = 7'd127; e.below = 1'b0;
        start_scan(32'd500, e, g);
        chk("busy_after_go", Busy, 1);
        chk("c_en_edge0", C_En, 0);
        @(negedge Clk);
        chk("c_addr_first", C_Addr, 0);
        chk("c_en_first", C_En, 1);
        wait_until(g + N);
        chk("c_addr_last", C_Addr, N - 1);
        chk("c_en_last", C_En, 1);
        @(negedge Clk);
        chk("c_en_drain", C_En, 0);
        chk("c_addr_drain", C_Addr, 0);
        chk("busy_drain", Busy, 1);
        wait_done(400);

        // 2: tie between addresses 5 and 77, lower index wins.
        for (int i = 0; i < N; i++) mem[i] = 32'd5000;
        mem[77] = 32'd3;
        mem[5]  = 32'd3;
        e.sad = 32'd3; e.idx = 7'd5; e.below = 1'b1;
        start_scan(32'd4, e, g);
        wait_done(400);

        // 3: all-ones everywhere; index 0 keeps it, not below all-ones threshold.
        for (int i = 0; i < N; i++) mem[i] = 32'hFFFF_FFFF;
        e.sad = 32'hFFFF_FFFF; e.idx = 7'd0; e.below = 1'b0;
        start_scan(32'hFFFF_FFFF, e, g);
        wait_done(400);

        // 4: reset at edge 60 of a scan, then recover.
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        start_scan(32'hFFFF_FFFF, model(32'hFFFF_FFFF), g);
        wait_until(g + 59);
        Rst_n = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        chk_zero("mid_reset");
        Rst_n = 1'b1;
        repeat (150) @(negedge Clk);
        chk("post_reset_idle_sad", Min_Sad, 0);
        mem[33] = 32'd7;
        start_scan(32'd0, model(32'd0), g);
        wait_done(400);
        for (int i = 0; i < N; i++) mem[i] = $urandom_range(100000, 10);
        start_scan(32'd50000, model(32'd50000), g);
        wait_done(400);

        // 5: Go pulses at edges 10 and 130 of a scan are ignored.
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        start_scan(32'h4000_0000, model(32'h4000_0000), g);
        wait_until(g + 9);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        chk("busy_ignore_go", Busy, 1);
        wait_until(g + 129);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        wait_done(400);
        repeat (20) @(negedge Clk);
        chk("no_restart_busy", Busy, 0);
        chk("no_restart_c_en", C_En, 0);
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        start_scan(32'h8000_0000, model(32'h8000_0000), g);
        wait_done(400);

        // 6: Go held high; scans chain every PERIOD edges, results change only at FIN.
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        Thresh = 32'h0800_0000;
        Go     = 1'b1;
        g      = cyc + 1;
        e      = model(Thresh);
        e.go_edge = g;
        exp_q.push_back(e);
        for (int s = 1; s < 3; s++) begin
            wait_until(g + 100);
            if (s > 1) begin
                chk("hold_min_sad", Min_Sad, last_exp.sad);
                chk("hold_min_idx", Min_Idx, last_exp.idx);
            end
            wait_until(g + LATENCY);
            last_exp = e;
            for (int i = 0; i < N; i++) mem[i] = $urandom;
            g = g + PERIOD;
            e = model(Thresh);
            e.go_edge = g;
            exp_q.push_back(e);
        end
        wait_until(g + 100);
        chk("hold2_min_sad", Min_Sad, last_exp.sad);
        chk("hold2_busy", Busy, 1);
        Go = 1'b0;
        wait_done(400);
        repeat (10) @(negedge Clk);
        chk("chain_stopped", Busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
